serial_add_sub: RTL and testbench

Multi-cycle, parametrised successor to the single-bit full-adder cell. It adds or subtracts two WIDTH-bit operands, processing BITS_PER_CYCLE bits per clock from LSB to MSB. Carry is held in a flip-flop between steps. Used where a full-width ripple adder is too large or too slow, and reports carry/borrow and signed overflow through a start/busy/done handshake.

---
 rtl/serial_add_sub.sv | 112 +++++++++++
 tb/tb_serial_add_sub.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB first,
// with the carry held in a flip-flop between slices.
module serial_add_sub #(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int unsigned BPC   = BITS_PER_CYCLE;
   localparam int unsigned STEPS = WIDTH / BPC;
   localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int unsigned IW    = $clog2(WIDTH);

   if (WIDTH < 2 || BPC == 0 || (WIDTH % BPC) != 0) begin : g_param_check
      $error("serial_add_sub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [BPC:0]     chain;
   logic [IW-1:0]    idx;
   logic             accept, last;

   assign accept = start && (state == S_IDLE || state == S_DONE);
   assign last   = (cnt == CW'(STEPS - 1));

   // One slice of the ripple chain; acc collects result bits so the visible
   // sum only changes when a full result is ready.
   always_comb begin
      chain    = '0;
      acc_nxt  = acc;
      idx      = '0;
      chain[0] = carry;
      for (int unsigned i = 0; i < BPC; i++) begin
         idx          = IW'(cnt * BPC + i);
         acc_nxt[idx] = opa[idx] ^ opb[idx] ^ chain[i];
         chain[i+1]   = (opa[idx] & opb[idx]) | ((opa[idx] ^ opb[idx]) & chain[i]);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last) state_nxt = S_DONE;
         S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opa      <= '0;
         opb      <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            // Subtraction runs as A + ~B + !bin through the same adder chain.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= c_in ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
         end else if (state == S_RUN) begin
            acc   <= acc_nxt;
            carry <= chain[BPC];
            cnt   <= cnt + CW'(1);
            if (last) begin
               sum      <= acc_nxt;
               c_out    <= chain[BPC];
               overflow <= chain[BPC] ^ chain[BPC-1];
               busy     <= 1'b0;
               done     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed-vector bench for serial_add_sub: 8-bit/1-bit-per-cycle table plus
// 16-bit/4-bit-per-cycle handshake, reset-abort and random-model checks.
module tb_serial_add_sub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, cout8, ov8;
   logic [7:0]  sum8;

   logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, cout16, ov16;
   logic [15:0] sum16;

   int tests  = 0;
   int failed = 0;

   serial_add_sub dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8), .sub(sub8),
      .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .overflow(ov8)
   );

   serial_add_sub #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c_in(cin16), .sub(sub16),
      .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16), .overflow(ov16)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
      logic       ov;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts,
                      output int lat, output logic bok);
      a8 = ta; b8 = tb_; cin8 = tc; sub8 = ts; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0; bok = 1'b1;
      while (!done8 && lat < 30) begin
         if (!busy8) bok = 1'b0;
         tick();
         lat++;
      end
      if (busy8) bok = 1'b0;
   endtask

   task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts,
                       output int lat);
      a16 = ta; b16 = tb_; cin16 = tc; sub16 = ts; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      lat = 0;
      while (!done16 && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   // Reference from plain integer arithmetic, independent of the adder chain.
   task automatic model16(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s,
                          output logic [15:0] r, output logic co, output logic ov);
      int sx, sy, sr;
      sx = $signed(x);
      sy = $signed(y);
      if (!s) begin
         {co, r} = 17'(x) + 17'(y) + 17'(c);
         sr = sx + sy + int'(c);
      end else begin
         r  = x - y - 16'(c);
         co = (17'(x) >= 17'(y) + 17'(c));
         sr = sx - sy - int'(c);
      end
      ov = (sr > 32767) || (sr < -32768);
   endtask

   initial begin
      int         lat, cnt;
      logic       bok, hold_ok;
      logic [15:0] er;
      logic       ec, eo;

      vt[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[1]  = '{8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};
      vt[2]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      vt[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      vt[4]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0};
      vt[5]  = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
      vt[6]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vt[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      vt[8]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vt[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
      vt[10] = '{8'h7F, 8'h80, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
      vt[11] = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};

      // Reset and idle behaviour
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_busy8", 32'(busy8), 0);
      check("rst_done8", 32'(done8), 0);
      check("rst_sum8",  32'(sum8),  0);
      check("rst_cout8", 32'(cout8), 0);
      check("rst_ov8",   32'(ov8),   0);
      check("rst_busy16", 32'(busy16), 0);
      check("rst_sum16",  32'(sum16),  0);
      cnt = 0;
      repeat (20) begin
         tick();
         if (done8 || done16) cnt++;
      end
      check("idle_no_done", 32'(cnt), 0);

      // Table of single operations, including the one-cycle done pulse
      for (int i = 0; i < 12; i++) begin
         op8(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, lat, bok);
         check($sformatf("v%0d_lat", i),  32'(lat), 8);
         check($sformatf("v%0d_busy", i), 32'(bok), 1);
         check($sformatf("v%0d_sum", i),  32'(sum8),  32'(vt[i].sum));
         check($sformatf("v%0d_cout", i), 32'(cout8), 32'(vt[i].cout));
         check($sformatf("v%0d_ov", i),   32'(ov8),   32'(vt[i].ov));
         tick();
         check($sformatf("v%0d_done_pulse", i), 32'(done8), 0);
         check($sformatf("v%0d_hold", i), 32'(sum8), 32'(vt[i].sum));
      end

      // start pulsed mid-operation with new operands is ignored
      a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; sub8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 3;
      while (!done8 && lat < 30) begin
         tick();
         lat++;
      end
      check("ign_lat",  32'(lat), 8);
      check("ign_sum",  32'(sum8), 32'h00);
      check("ign_cout", 32'(cout8), 1);
      tick();

      // Back-to-back: start held in the DONE cycle
      op8(8'h12, 8'h34, 1'b0, 1'b0, lat, bok);
      check("b2b_first_sum", 32'(sum8), 32'h46);
      a8 = 8'h05; b8 = 8'h07; cin8 = 1'b0; sub8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("b2b_busy", 32'(busy8), 1);
      lat = 0; hold_ok = 1'b1;
      while (!done8 && lat < 30) begin
         if (sum8 !== 8'h46 || cout8 !== 1'b0 || ov8 !== 1'b0) hold_ok = 1'b0;
         tick();
         lat++;
      end
      check("b2b_lat",  32'(lat), 8);
      check("b2b_hold", 32'(hold_ok), 1);
      check("b2b_sum",  32'(sum8), 32'hFE);
      check("b2b_cout", 32'(cout8), 0);
      tick();

      // Wide config: reset aborts a running operation
      op16(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
      check("w_pre_sum", 32'(sum16), 32'h2345);
      a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 32'(busy16), 0);
      check("abort_done", 32'(done16), 0);
      check("abort_sum",  32'(sum16),  0);
      check("abort_cout", 32'(cout16), 0);
      check("abort_ov",   32'(ov16),   0);
      cnt = 0;
      repeat (10) begin
         tick();
         if (done16) cnt++;
      end
      check("abort_no_done", 32'(cnt), 0);

      op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
      check("w_lat",  32'(lat), 4);
      check("w_sum",  32'(sum16), 32'h0000);
      check("w_cout", 32'(cout16), 1);
      check("w_ov",   32'(ov16), 0);
      tick();

      for (int n = 0; n < 1000; n++) begin
         logic [15:0] ra, rb;
         logic        rc, rs;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         model16(ra, rb, rc, rs, er, ec, eo);
         op16(ra, rb, rc, rs, lat);
         check($sformatf("r%0d_lat", n),  32'(lat), 4);
         check($sformatf("r%0d_sum", n),  32'(sum16), 32'(er));
         check($sformatf("r%0d_cout", n), 32'(cout16), 32'(ec));
         check($sformatf("r%0d_ov", n),   32'(ov16), 32'(eo));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
